// File: rtl/tetris_pkg.sv
// Shared playfield types and dimensions used by the reader path.
package tetris_pkg;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef logic [3:0] cell_t;
  typedef cell_t [ROWS-1:0][COLS-1:0] pixmap_t;

  localparam cell_t CELL_EMPTY = 4'h0;
  localparam cell_t CELL_GRID  = 4'hF;

  typedef enum logic {
    WAIT_VS,
    ARMED
  } rdr_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pf_cell_addr.sv
// First lookup stage: screen pixel -> playfield cell row/col plus in-field flag.
// With PF_GRID_LINES_EN defined it also flags pixels on a cell boundary.
module pf_cell_addr
  import tetris_pkg::*;
#(
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 40,
  parameter int CELL_SHIFT = 4
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic [9:0]       draw_x,
  input  logic [9:0]       draw_y,
  input  logic             draw_en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             inf,
  output logic             en_d
`ifdef PF_GRID_LINES_EN
 ,output logic             on_grid
`endif
);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] col_full;
  logic signed [10:0] row_full;
  logic               in_range;

  assign dx       = $signed({1'b0, draw_x}) - $signed(11'(ORIGIN_X));
  assign dy       = $signed({1'b0, draw_y}) - $signed(11'(ORIGIN_Y));
  assign col_full = dx >>> CELL_SHIFT;
  assign row_full = dy >>> CELL_SHIFT;

  // Sign bits are checked first so a negative offset never reaches the index.
  assign in_range = !dx[10] && !dy[10] &&
                    (col_full < $signed(11'(COLS))) &&
                    (row_full < $signed(11'(ROWS)));

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      row     <= '0;
      col     <= '0;
      inf     <= 1'b0;
      en_d    <= 1'b0;
`ifdef PF_GRID_LINES_EN
      on_grid <= 1'b0;
`endif
    end else begin
      inf     <= in_range;
      en_d    <= draw_en;
      row     <= in_range ? row_full[ROW_W-1:0] : '0;
      col     <= in_range ? col_full[COL_W-1:0] : '0;
`ifdef PF_GRID_LINES_EN
      on_grid <= (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);
`endif
    end
  end

endmodule

// File: rtl/playfield_reader.sv
// Snapshots the live PixelMap once per frame and serves cells to the colour mapper.
// Optional grid overlay is enabled by defining PF_GRID_LINES_EN.
//
// state   | meaning
// WAIT_VS | snapshot taken (or frame given up); waiting for the next vsync
// ARMED   | new frame started; capture on the first cycle the map is stable
module playfield_reader
  import tetris_pkg::*;
#(
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 40,
  parameter int CELL_SHIFT = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  pixmap_t    PixelMapIn,
  input  logic       map_stable,
  input  logic       vsync_pulse,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       draw_en,
  output cell_t      cell_code,
  output logic       in_field,
  output logic       pix_valid,
  output logic       snap_fresh,
  output logic [7:0] missed_frames
);

  rdr_state_t       state;
  pixmap_t          snapshot;
  logic [ROW_W-1:0] s1_row;
  logic [COL_W-1:0] s1_col;
  logic             s1_inf;
  logic             s1_en;
  logic             deadline;
`ifdef PF_GRID_LINES_EN
  logic             s1_grid;
`endif

  pf_cell_addr #(
    .ORIGIN_X   (ORIGIN_X),
    .ORIGIN_Y   (ORIGIN_Y),
    .CELL_SHIFT (CELL_SHIFT)
  ) u_cell_addr (
    .clk_sys (Clk),
    .rst_b   (Reset),
    .draw_x  (DrawX),
    .draw_y  (DrawY),
    .draw_en (draw_en),
    .row     (s1_row),
    .col     (s1_col),
    .inf     (s1_inf),
    .en_d    (s1_en)
`ifdef PF_GRID_LINES_EN
   ,.on_grid (s1_grid)
`endif
  );

  // Once active video reaches the field's first line the frame can no longer be tear-free.
  assign deadline = draw_en && (DrawY >= 10'(ORIGIN_Y));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= WAIT_VS;
      snapshot      <= '0;
      snap_fresh    <= 1'b0;
      missed_frames <= 8'd0;
    end else begin
      case (state)
        WAIT_VS: begin
          if (vsync_pulse) begin
            state      <= ARMED;
            snap_fresh <= 1'b0;
          end
        end
        ARMED: begin
          if (map_stable) begin
            snapshot   <= PixelMapIn;
            snap_fresh <= 1'b1;
            state      <= WAIT_VS;
          end else if (vsync_pulse) begin
            missed_frames <= sat_inc8(missed_frames);
          end else if (deadline) begin
            missed_frames <= sat_inc8(missed_frames);
            state         <= WAIT_VS;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  // S2 reads the registered snapshot, so a same-cycle capture shows up one cycle later.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cell_code <= CELL_EMPTY;
      in_field  <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      in_field  <= s1_inf;
      pix_valid <= s1_en;
      if (!s1_inf) begin
        cell_code <= CELL_EMPTY;
`ifdef PF_GRID_LINES_EN
      end else if (s1_grid) begin
        cell_code <= CELL_GRID;
`endif
      end else begin
        cell_code <= snapshot[s1_row][s1_col];
      end
    end
  end

endmodule

// File: tb/tb_playfield_reader.sv
// Self-checking bench for playfield_reader: frame-capture model plus lookup scoreboard.
module tb_playfield_reader;
  import tetris_pkg::*;

  localparam int OX = 240;
  localparam int OY = 40;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  pixmap_t    map_in = '0;
  logic       map_stable = 1'b0;
  logic       vsync_pulse = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       draw_en = 1'b0;
  cell_t      cell_code;
  logic       in_field;
  logic       pix_valid;
  logic       snap_fresh;
  logic [7:0] missed_frames;

  typedef struct {
    int   x;
    int   y;
    logic en;
  } pix_t;

  pix_t    sb_q[$];
  pixmap_t ref_map = '0;
  logic    ref_armed = 1'b0;
  logic    ref_fresh = 1'b0;
  int      ref_missed = 0;
  int      errors = 0;
  int      checks = 0;

  playfield_reader #(
    .ORIGIN_X   (OX),
    .ORIGIN_Y   (OY),
    .CELL_SHIFT (4)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PixelMapIn    (map_in),
    .map_stable    (map_stable),
    .vsync_pulse   (vsync_pulse),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .draw_en       (draw_en),
    .cell_code     (cell_code),
    .in_field      (in_field),
    .pix_valid     (pix_valid),
    .snap_fresh    (snap_fresh),
    .missed_frames (missed_frames)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // One clock: drive, push expectation, check matured lookup, advance the frame model.
  task automatic cycle(input int x, input int y, input logic en, input logic vs, input logic stable);
    pix_t  p;
    pix_t  e;
    int    dx;
    int    dy;
    logic  inf;
    cell_t code;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    draw_en     = en;
    vsync_pulse = vs;
    map_stable  = stable;
    p.x = x; p.y = y; p.en = en;
    sb_q.push_back(p);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 2) begin
      e    = sb_q.pop_front();
      dx   = e.x - OX;
      dy   = e.y - OY;
      inf  = (dx >= 0) && (dy >= 0) && (dx < COLS * 16) && (dy < ROWS * 16);
      code = CELL_EMPTY;
      if (inf) code = ref_map[dy / 16][dx / 16];
`ifdef PF_GRID_LINES_EN
      if (inf && ((dx % 16) == 0 || (dy % 16) == 0)) code = 4'hF;
`endif
      checks += 3;
      if (cell_code !== code) begin
        errors++;
        $display("FAIL lookup_code x=%0d y=%0d: got %h expected %h", e.x, e.y, cell_code, code);
      end
      if (in_field !== inf) begin
        errors++;
        $display("FAIL lookup_in_field x=%0d y=%0d: got %b expected %b", e.x, e.y, in_field, inf);
      end
      if (pix_valid !== e.en) begin
        errors++;
        $display("FAIL lookup_pix_valid x=%0d y=%0d: got %b expected %b", e.x, e.y, pix_valid, e.en);
      end
    end
    if (!ref_armed) begin
      if (vs) begin
        ref_armed = 1'b1;
        ref_fresh = 1'b0;
      end
    end else if (stable) begin
      ref_map   = map_in;
      ref_fresh = 1'b1;
      ref_armed = 1'b0;
    end else if (vs) begin
      if (ref_missed < 255) ref_missed++;
    end else if (en && y >= OY) begin
      if (ref_missed < 255) ref_missed++;
      ref_armed = 1'b0;
    end
    checks += 2;
    if (snap_fresh !== ref_fresh) begin
      errors++;
      $display("FAIL frame_snap_fresh: got %b expected %b", snap_fresh, ref_fresh);
    end
    if (missed_frames !== 8'(ref_missed)) begin
      errors++;
      $display("FAIL frame_missed: got %0d expected %0d", missed_frames, ref_missed);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; draw_en = 1'b1; DrawX = 10'd250; DrawY = 10'd50;
    map_stable = 1'b1; vsync_pulse = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks += 5;
    if (cell_code !== 4'h0) begin errors++; $display("FAIL reset_cell_code: got %h expected 0", cell_code); end
    if (in_field !== 1'b0) begin errors++; $display("FAIL reset_in_field: got %b expected 0", in_field); end
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
    if (snap_fresh !== 1'b0) begin errors++; $display("FAIL reset_snap_fresh: got %b expected 0", snap_fresh); end
    if (missed_frames !== 8'd0) begin errors++; $display("FAIL reset_missed: got %0d expected 0", missed_frames); end
    Reset = 1'b1;
    sb_q.delete();
    ref_map = '0; ref_armed = 1'b0; ref_fresh = 1'b0; ref_missed = 0;
  endtask

  task automatic test_capture();
    map_in        = '0;
    map_in[0][0]  = 4'h3;
    map_in[0][1]  = 4'h5;
    map_in[5][4]  = 4'h9;
    map_in[19][9] = 4'h7;
    cycle(0, 0, 1'b0, 1'b1, 1'b1);
    cycle(0, 0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (snap_fresh !== 1'b1) begin errors++; $display("FAIL capture_fresh: got %b expected 1", snap_fresh); end
    cycle(240, 40, 1'b1, 1'b0, 1'b0);
    cycle(248, 48, 1'b1, 1'b0, 1'b0);
    cycle(256, 50, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (cell_code !== 4'h3) begin errors++; $display("FAIL capture_cell00: got %h expected 3", cell_code); end
    if (in_field !== 1'b1) begin errors++; $display("FAIL capture_in_field: got %b expected 1", in_field); end
    cycle(305, 121, 1'b1, 1'b0, 1'b0);
    cycle(265, 45, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_miss();
    map_in[0][0] = 4'hA;
    cycle(0, 0, 1'b0, 1'b1, 1'b0);
    cycle(240, 20, 1'b1, 1'b0, 1'b0);
    cycle(240, 40, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (missed_frames !== 8'd1) begin errors++; $display("FAIL miss_count: got %0d expected 1", missed_frames); end
    if (snap_fresh !== 1'b0) begin errors++; $display("FAIL miss_fresh: got %b expected 0", snap_fresh); end
    cycle(248, 48, 1'b1, 1'b0, 1'b1);
    cycle(240, 40, 1'b1, 1'b0, 1'b1);
    checks++;
    if (cell_code !== 4'h3) begin errors++; $display("FAIL miss_old_cell: got %h expected 3", cell_code); end
    cycle(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries();
    cycle(239, 48, 1'b1, 1'b0, 1'b0);
    cycle(400, 48, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (in_field !== 1'b0) begin errors++; $display("FAIL bound_x239_in_field: got %b expected 0", in_field); end
    if (cell_code !== 4'h0) begin errors++; $display("FAIL bound_x239_code: got %h expected 0", cell_code); end
    cycle(399, 359, 1'b1, 1'b0, 1'b0);
    cycle(240, 39, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (cell_code !== 4'h7) begin errors++; $display("FAIL bound_last_cell: got %h expected 7", cell_code); end
    if (in_field !== 1'b1) begin errors++; $display("FAIL bound_last_in_field: got %b expected 1", in_field); end
    cycle(240, 360, 1'b1, 1'b0, 1'b0);
    cycle(399, 40, 1'b0, 1'b0, 1'b0);
    cycle(0, 0, 1'b1, 1'b0, 1'b0);
    cycle(1023, 1023, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle();
    map_in[0][0] = 4'hB;
    cycle(248, 48, 1'b1, 1'b1, 1'b1);
    cycle(248, 48, 1'b1, 1'b0, 1'b1);
    checks += 2;
    if (cell_code !== 4'h3) begin errors++; $display("FAIL same_cycle_old: got %h expected 3", cell_code); end
    if (missed_frames !== 8'd1) begin errors++; $display("FAIL same_cycle_no_miss: got %0d expected 1", missed_frames); end
    cycle(248, 48, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cell_code !== 4'hB) begin errors++; $display("FAIL same_cycle_new: got %h expected b", cell_code); end
    cycle(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_vsync_armed();
    map_in[5][4] = 4'h2;
    cycle(0, 0, 1'b0, 1'b1, 1'b0);
    cycle(0, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (missed_frames !== 8'd2) begin errors++; $display("FAIL vsync_armed_miss: got %0d expected 2", missed_frames); end
    cycle(0, 0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (snap_fresh !== 1'b1) begin errors++; $display("FAIL vsync_armed_capture: got %b expected 1", snap_fresh); end
    cycle(305, 121, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 300; f++) begin
      if (f % 3 == 0) begin
        cycle(0, 0, 1'b0, 1'b1, 1'b0);
        cycle(0, 60, 1'b1, 1'b0, 1'b0);
      end else begin
        cycle(0, 0, 1'b0, 1'b1, 1'b0);
      end
    end
    checks++;
    if (missed_frames !== 8'd255) begin errors++; $display("FAIL saturation: got %0d expected 255", missed_frames); end
    cycle(0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_armed();
    cycle(248, 48, 1'b0, 1'b0, 1'b0);
    cycle(248, 48, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0; draw_en = 1'b1; vsync_pulse = 1'b0; map_stable = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    checks += 4;
    if (cell_code !== 4'h0) begin errors++; $display("FAIL mid_reset_code: got %h expected 0", cell_code); end
    if (missed_frames !== 8'd0) begin errors++; $display("FAIL mid_reset_missed: got %0d expected 0", missed_frames); end
    if (snap_fresh !== 1'b0) begin errors++; $display("FAIL mid_reset_fresh: got %b expected 0", snap_fresh); end
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_pix_valid: got %b expected 0", pix_valid); end
    sb_q.delete();
    ref_map = '0; ref_armed = 1'b0; ref_fresh = 1'b0; ref_missed = 0;
    cycle(248, 48, 1'b1, 1'b0, 1'b1);
    cycle(248, 48, 1'b1, 1'b0, 1'b1);
    cycle(0, 0, 1'b0, 1'b0, 1'b1);
    checks += 2;
    if (snap_fresh !== 1'b0) begin errors++; $display("FAIL mid_reset_wait_vs: got %b expected 0", snap_fresh); end
    if (cell_code !== 4'h0) begin errors++; $display("FAIL mid_reset_snapshot: got %h expected 0", cell_code); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_miss();
    test_boundaries();
    test_same_cycle();
    test_vsync_armed();
    test_saturation();
    test_reset_mid_armed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
